instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Fetch stage upstream of the single-cycle datapath. Holds the fetch PC and
//   issues word requests to a handshaked instruction memory. Buffers returned
//   words with their addresses in a DEPTH-entry FIFO, which feeds decode via valid/ready.
//   A redirect from execute (branch taken) flushes the queue and any in-flight response.
// PARAMETERS
//   DEPTH     4          FIFO entries; power of two, >= 2
//   RESET_PC  32'h0      fetch address after reset; bits [1:0] must be 0
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst             in   1   synchronous reset, active-high
//   imem_req        out  1   request valid to instruction memory (registered)
//   imem_addr       out  32  word address of current request (registered)
//   imem_ack        in   1   memory completes request this cycle; imem_rdata valid
//   imem_rdata      in   32  instruction word, sampled only when imem_req & imem_ack
//   redirect_valid  in   1   branch redirect this cycle
//   redirect_pc     in   32  new fetch address; bits [1:0] forced to 0
//   ins_valid       out  1   FIFO head valid (count != 0)
//   ins             out  32  FIFO head instruction; 0 when ins_valid=0
//   ins_Addr        out  32  FIFO head address; 0 when ins_valid=0
//   ins_ready       in   1   decode accepts head; pop when ins_valid & ins_ready
//   queue_count     out  clog2(DEPTH)+1  entries held
// BEHAVIOUR
//   Reset: state=IDLE, fetch_pc=RESET_PC, count=0, rd/wr ptrs=0, imem_req=0,
//     imem_addr=RESET_PC, ins_valid=0, ins=0, ins_Addr=0, queue_count=0.
//   Requests: at most one outstanding. imem_req/imem_addr held stable until ack.
//   count_next = count + push - pop (push = accepted ack in REQ; pop = valid&ready).
//   States:
//     IDLE: if count_next < DEPTH -> REQ (imem_req=1, imem_addr=fetch_pc next cycle).
//     REQ : ack & ~redirect -> push {fetch_pc, imem_rdata}; fetch_pc+=4;
//             stay REQ with new addr if count_next < DEPTH, else IDLE.
//           ~ack & redirect -> DROP (keep req to old addr until ack).
//           ack & redirect  -> discard word; -> IDLE.
//     DROP: imem_req=1 at old addr; on ack discard rdata -> IDLE.
//           A further redirect in DROP updates fetch_pc only.
//   Redirect (any state): FIFO flushed (count=0, ptrs=0) and fetch_pc=
//     {redirect_pc[31:2],2'b00} next cycle; overrides push and pop same cycle.
//   Latency: ack in cycle N -> entry at ins_valid in N+1. Zero-wait memory with
//     ins_ready=1 sustains one instruction per cycle.
//   Full: no request issued while count_next == DEPTH; resumes the cycle after a pop.
//   Push and pop in same cycle: count unchanged, head advances.
//   Ordering: entries leave in fetch order; ins_Addr of consecutive entries
//     differs by 4 unless a redirect intervened.
//   fetch_pc wraps modulo 2^32 (0xFFFFFFFC + 4 = 0x0).
//   Reset asserted mid-request: imem_req drops next cycle; pending ack ignored.
// TESTING
//   1. RESET_PC=0x100, rst high 2 cycles -> imem_req=0, ins_valid=0; first cycle
//      after release imem_req=1, imem_addr=0x100.
//   2. imem_ack=1 every cycle, ins_ready=1 -> ins_Addr 0x100,0x104,0x108...
//      one per cycle, ins = supplied rdata, no bubbles.
//   3. ins_ready=0, ack always -> exactly 4 pushes, imem_req=0 after 4th ack,
//      queue_count=4, head holds 0x100; raise ready -> drains in order, fetch resumes.
//   4. Request at 0x108 pending, redirect_pc=0x200, ack 3 cycles later with
//      0xDEADBEEF -> word discarded, ins_valid=0, next imem_addr=0x200.
//   5. Redirect, pop and ack in same cycle (count=2) -> next cycle queue_count=0,
//      ins_valid=0, imem_addr=redirect_pc.
//   6. redirect_pc=0x203 -> imem_addr=0x200; fetch_pc 0xFFFFFFFC + ack -> next 0x0.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: issues one word request at a time to a handshaked
// instruction memory and buffers returned words, tagged with their fetch
// addresses, in a small FIFO that feeds decode. A taken-branch redirect
// flushes the FIFO and discards any response still in flight.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     ins_valid,
    output logic [31:0]              ins,
    output logic [31:0]              ins_Addr,
    input  logic                     ins_ready,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // IDLE: no request; REQ: live request; DROP: request whose word is discarded
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           imem_req_q, imem_req_d;
    logic [31:0]    imem_addr_q, imem_addr_d;
    logic [CW-1:0]  count_q, count_d, count_nx;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;

    logic [31:0]    addr_mem [DEPTH];
    logic [31:0]    data_mem [DEPTH];

    logic           push;
    logic           pop;
    logic           has_room;
    logic [31:0]    redirect_pc_aligned;

    assign redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;

    // A word is only kept when it answers a live request and no redirect
    // arrives in the same cycle (the redirect makes it stale).
    assign push      = (state_q == REQ) & imem_ack & ~redirect_valid;
    assign pop       = ins_valid & ins_ready;
    assign count_nx  = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign has_room  = count_nx < CW'(DEPTH);

    assign ins_valid   = (count_q != '0);
    assign ins         = ins_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign ins_Addr    = ins_valid ? addr_mem[rd_ptr_q] : 32'h0;
    assign queue_count = count_q;
    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;

    // Fetch FSM next state, next fetch PC and next request registers
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            IDLE: begin
                // A redirect empties the FIFO, so there is always room after it
                if (redirect_valid || has_room) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        state_d = IDLE;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = has_room ? REQ : IDLE;
                    end
                end else if (redirect_valid) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc_aligned;
        end
        // The memory must see the abandoned address until it acknowledges it
        imem_req_d  = (state_d != IDLE);
        imem_addr_d = (state_d == DROP) ? imem_addr_q : fetch_pc_d;
    end

    // FIFO occupancy and pointers; a redirect flush overrides push and pop
    always_comb begin
        count_d  = count_nx;
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);
        if (redirect_valid) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end
    end

    // Control and pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // FIFO storage: address and word of each accepted response
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= fetch_pc_q;
            data_mem[wr_ptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a reference model tracks the
// fetch PC and the expected FIFO contents; entries are pushed when a word is
// accepted and popped/compared when decode takes the head.
module tb_instr_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_Addr;
    logic        ins_ready;
    logic [2:0]  queue_count;

    instr_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h100)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins            (ins),
        .ins_Addr       (ins_Addr),
        .ins_ready      (ins_ready),
        .queue_count    (queue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    int          n_push      = 0;
    int          n_pop       = 0;

    logic [63:0] sb [$];
    logic [31:0] model_pc;
    logic [31:0] drop_addr;
    bit          drop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; checks outputs, drives inputs for the next edge,
    // advances the model, and returns at the following negedge.
    task automatic cycle(input bit ack_want, input logic [31:0] rdata,
                         input bit redir, input logic [31:0] rpc, input bit rdy);
        logic [63:0] e;
        check("count", {29'b0, queue_count}, 32'(sb.size()));
        check("valid", {31'b0, ins_valid}, {31'b0, sb.size() != 0});
        if (!ins_valid) begin
            check("ins_zero", ins, 32'h0);
            check("addr_zero", ins_Addr, 32'h0);
        end
        imem_ack       = ack_want & imem_req;
        imem_rdata     = imem_ack ? rdata : 32'h0;
        redirect_valid = redir;
        redirect_pc    = rpc;
        ins_ready      = rdy;
        if (imem_req && !drop) check("req_addr", imem_addr, model_pc);
        if (imem_req && drop)  check("drop_addr", imem_addr, drop_addr);
        if (ins_valid && rdy && !redir) begin
            if (sb.size() == 0) begin
                check("underflow", 32'h1, 32'h0);
            end else begin
                e = sb.pop_front();
                check("pop_addr", ins_Addr, e[63:32]);
                check("pop_data", ins, e[31:0]);
                n_pop++;
            end
        end
        if (redir) begin
            sb.delete();
            if (imem_req && !imem_ack && !drop) begin
                drop      = 1'b1;
                drop_addr = model_pc;
            end else if (imem_req && imem_ack && drop) begin
                drop = 1'b0;
            end
            model_pc = rpc & 32'hFFFF_FFFC;
        end else if (imem_req && imem_ack) begin
            if (drop) begin
                drop = 1'b0;
            end else begin
                sb.push_back({model_pc, rdata});
                model_pc = model_pc + 32'd4;
                n_push++;
            end
        end
        @(negedge clk);
        imem_ack       = 1'b0;
        redirect_valid = 1'b0;
        ins_ready      = 1'b0;
    endtask

    // Two reset cycles, reset-state checks, then the first request after release
    task automatic do_reset();
        rst            = 1'b1;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        ins_ready      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, ins_valid}, 32'h0);
        check("rst_count", {29'b0, queue_count}, 32'h0);
        check("rst_addr", imem_addr, 32'h100);
        rst = 1'b0;
        sb.delete();
        model_pc = 32'h100;
        drop     = 1'b0;
        n_push   = 0;
        n_pop    = 0;
        @(negedge clk);
        check("rel_req", {31'b0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'h100);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);

        // Reset and streaming at one instruction per cycle
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
        check("stream_pops", 32'(n_pop), 32'd11);

        // Fill to capacity with decode stalled, then drain
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        check("full_pushes", 32'(n_push), 32'd4);
        check("full_req", {31'b0, imem_req}, 32'h0);
        check("full_count", {29'b0, queue_count}, 32'd4);
        check("full_head", ins_Addr, 32'h100);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("resume_req", {31'b0, imem_req}, 32'h1);
        check("resume_addr", imem_addr, 32'h110);
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);

        // Redirect while a request is pending; late response is discarded
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
        check("pend_addr", imem_addr, 32'h108);
        cycle(1'b0, 32'h0, 1'b1, 32'h200, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1);
        check("drop_valid", {31'b0, ins_valid}, 32'h0);
        check("drop_next", imem_addr, 32'h200);
        cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
        check("redir_req", {31'b0, imem_req}, 32'h1);
        check("redir_addr", imem_addr, 32'h200);

        // Redirect, pop and ack in the same cycle with two entries held
        do_reset();
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b0);
        check("two_count", {29'b0, queue_count}, 32'd2);
        cycle(1'b1, $urandom, 1'b1, 32'h300, 1'b1);
        check("flush_count", {29'b0, queue_count}, 32'h0);
        check("flush_valid", {31'b0, ins_valid}, 32'h0);
        check("flush_addr", imem_addr, 32'h300);

        // Unaligned redirect target and PC wrap
        cycle(1'b0, 32'h0, 1'b1, 32'h203, 1'b1);
        check("align_addr", imem_addr, 32'h200);
        cycle(1'b1, $urandom, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);
        check("wrap_addr", imem_addr, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);

        // Random traffic with stalls, back-pressure and occasional redirects
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 19) == 0, $urandom,
                  $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 8; i++) cycle(1'b1, $urandom, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
